// File: rtl/z_buffer_stream.sv
// Streaming depth-test unit: read-compare-conditional-write against a word-addressed
// depth buffer, with clear engine, bypass paths and saturating pass/fail statistics.
module z_buffer_stream #(
   parameter int Z_SIZE    = 16,
   parameter int X_RES     = 640,
   parameter int Y_RES     = 480,
   parameter int X_W       = $clog2(X_RES),
   parameter int Y_W       = $clog2(Y_RES),
   parameter int ADDR_SIZE = 32,
   parameter int CNT_W     = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 frag_valid_i,
   output logic                 frag_ready_o,
   input  logic [X_W-1:0]       frag_x_i,
   input  logic [Y_W-1:0]       frag_y_i,
   input  logic [Z_SIZE-1:0]    frag_z_i,
   input  logic [2:0]           depth_func_i,
   input  logic                 depth_test_en_i,
   input  logic                 depth_write_en_i,
   input  logic [ADDR_SIZE-1:0] base_addr_i,
   input  logic [Z_SIZE-1:0]    clear_value_i,
   input  logic                 clear_start_i,
   output logic                 clear_busy_o,
   output logic                 clear_done_o,
   output logic                 rd_req_valid_o,
   input  logic                 rd_req_ready_i,
   output logic [ADDR_SIZE-1:0] rd_addr_o,
   input  logic                 rd_resp_valid_i,
   output logic                 rd_resp_ready_o,
   input  logic [Z_SIZE-1:0]    rd_resp_data_i,
   output logic                 wr_valid_o,
   input  logic                 wr_ready_i,
   output logic [ADDR_SIZE-1:0] wr_addr_o,
   output logic [Z_SIZE-1:0]    wr_data_o,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic                 res_pass_o,
   output logic [X_W-1:0]       res_x_o,
   output logic [Y_W-1:0]       res_y_o,
   output logic [Z_SIZE-1:0]    res_z_o,
   output logic [CNT_W-1:0]     pass_cnt_o,
   output logic [CNT_W-1:0]     fail_cnt_o,
   input  logic                 stats_clr_i
);

   localparam int unsigned PIX   = X_RES * Y_RES;
   localparam int          CLR_W = $clog2(PIX + 1);
   localparam logic [X_W:0] L_XR = (X_W+1)'(X_RES);
   localparam logic [Y_W:0] L_YR = (Y_W+1)'(Y_RES);

   localparam logic [2:0] F_NEVER  = 3'd0;
   localparam logic [2:0] F_LESS   = 3'd1;
   localparam logic [2:0] F_LEQUAL = 3'd2;
   localparam logic [2:0] F_GREATER= 3'd3;
   localparam logic [2:0] F_GEQUAL = 3'd4;
   localparam logic [2:0] F_EQUAL  = 3'd5;
   localparam logic [2:0] F_ALWAYS = 3'd7;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WRITE, RESULT, CLEAR} state_t;

   state_t                r_state, w_next;
   logic [X_W-1:0]        r_x;
   logic [Y_W-1:0]        r_y;
   logic [Z_SIZE-1:0]     r_z;
   logic [2:0]            r_func;
   logic                  r_wr_en;
   logic [ADDR_SIZE-1:0]  r_addr;
   logic                  r_pass;
   logic                  r_rd_req_valid, r_rd_resp_ready, r_wr_valid, r_res_valid;
   logic                  r_clear_busy, r_clear_done;
   logic [ADDR_SIZE-1:0]  r_wr_addr;
   logic [Z_SIZE-1:0]     r_wr_data;
   logic [CLR_W-1:0]      r_clr_idx;
   logic [CNT_W-1:0]      r_pass_cnt, r_fail_cnt;

   logic                  w_oob, w_cmp, w_bypass_pass, w_clr_last;
   logic                  w_rd_hs, w_resp_hs, w_wr_hs, w_res_hs;
   logic [ADDR_SIZE-1:0]  w_addr;

   assign w_oob      = ({1'b0, frag_x_i} >= L_XR) || ({1'b0, frag_y_i} >= L_YR);
   assign w_addr     = base_addr_i + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES) + ADDR_SIZE'(frag_x_i);
   assign w_clr_last = (r_clr_idx == CLR_W'(PIX - 1));
   assign w_rd_hs    = r_rd_req_valid && rd_req_ready_i;
   assign w_resp_hs  = r_rd_resp_ready && rd_resp_valid_i;
   assign w_wr_hs    = r_wr_valid && wr_ready_i;
   assign w_res_hs   = r_res_valid && res_ready_i;

   // Fragment depth is the left operand of every comparison.
   always_comb begin
      w_cmp = 1'b0;
      case (r_func)
         F_NEVER:   w_cmp = 1'b0;
         F_LESS:    w_cmp = r_z <  rd_resp_data_i;
         F_LEQUAL:  w_cmp = r_z <= rd_resp_data_i;
         F_GREATER: w_cmp = r_z >  rd_resp_data_i;
         F_GEQUAL:  w_cmp = r_z >= rd_resp_data_i;
         F_EQUAL:   w_cmp = r_z == rd_resp_data_i;
         F_ALWAYS:  w_cmp = 1'b1;
         default:   w_cmp = r_z != rd_resp_data_i;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_bypass_pass = 1'b0;
      case (r_state)
         IDLE: begin
            if (clear_start_i) begin
               w_next = CLEAR;
            end else if (frag_valid_i) begin
               if (w_oob) begin
                  w_next = RESULT;
               end else if (!depth_test_en_i) begin
                  w_next        = RESULT;
                  w_bypass_pass = 1'b1;
               end else if (depth_func_i == F_NEVER) begin
                  w_next = RESULT;
               end else if (depth_func_i == F_ALWAYS) begin
                  w_bypass_pass = 1'b1;
                  w_next        = depth_write_en_i ? WRITE : RESULT;
               end else begin
                  w_next = RD_REQ;
               end
            end
         end
         RD_REQ:  if (w_rd_hs)   w_next = RD_RESP;
         RD_RESP: if (w_resp_hs) w_next = (w_cmp && r_wr_en) ? WRITE : RESULT;
         WRITE:   if (w_wr_hs)   w_next = RESULT;
         RESULT:  if (w_res_hs)  w_next = IDLE;
         CLEAR:   if (w_wr_hs && w_clr_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Handshake outputs are flopped from the next state so each is valid the cycle the state is entered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_x <= '0; r_y <= '0; r_z <= '0; r_func <= '0; r_wr_en <= 1'b0;
         r_addr <= '0; r_pass <= 1'b0;
         r_rd_req_valid <= 1'b0; r_rd_resp_ready <= 1'b0;
         r_wr_valid <= 1'b0; r_res_valid <= 1'b0;
         r_clear_busy <= 1'b0; r_clear_done <= 1'b0;
         r_wr_addr <= '0; r_wr_data <= '0; r_clr_idx <= '0;
         r_pass_cnt <= '0; r_fail_cnt <= '0;
      end else begin
         r_rd_req_valid  <= (w_next == RD_REQ);
         r_rd_resp_ready <= (w_next == RD_RESP);
         r_wr_valid      <= (w_next == WRITE) || (w_next == CLEAR);
         r_res_valid     <= (w_next == RESULT);
         r_clear_busy    <= (w_next == CLEAR);
         r_clear_done    <= (r_state == CLEAR) && w_wr_hs && w_clr_last;
         case (r_state)
            IDLE: begin
               if (clear_start_i) begin
                  r_wr_addr <= base_addr_i;
                  r_wr_data <= clear_value_i;
                  r_clr_idx <= '0;
               end else if (frag_valid_i) begin
                  r_x       <= frag_x_i;
                  r_y       <= frag_y_i;
                  r_z       <= frag_z_i;
                  r_func    <= depth_func_i;
                  r_wr_en   <= depth_write_en_i;
                  r_addr    <= w_addr;
                  r_pass    <= w_bypass_pass;
                  r_wr_addr <= w_addr;
                  r_wr_data <= frag_z_i;
               end
            end
            RD_RESP: if (w_resp_hs) r_pass <= w_cmp;
            CLEAR: begin
               if (w_wr_hs) begin
                  r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
                  r_clr_idx <= r_clr_idx + CLR_W'(1);
               end
            end
            default: ;
         endcase
         if (stats_clr_i) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
         end else if (w_res_hs) begin
            if (r_pass) begin
               if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end else begin
               if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign frag_ready_o    = (r_state == IDLE) && !clear_start_i;
   assign clear_busy_o    = r_clear_busy;
   assign clear_done_o    = r_clear_done;
   assign rd_req_valid_o  = r_rd_req_valid;
   assign rd_addr_o       = r_addr;
   assign rd_resp_ready_o = r_rd_resp_ready;
   assign wr_valid_o      = r_wr_valid;
   assign wr_addr_o       = r_wr_addr;
   assign wr_data_o       = r_wr_data;
   assign res_valid_o     = r_res_valid;
   assign res_pass_o      = r_pass;
   assign res_x_o         = r_x;
   assign res_y_o         = r_y;
   assign res_z_o         = r_z;
   assign pass_cnt_o      = r_pass_cnt;
   assign fail_cnt_o      = r_fail_cnt;

endmodule

// File: doc/z_buffer_stream.md
# z_buffer_stream

Parametrised, streaming depth-test unit for the rasteriser, next generation of the single-shot Z-buffer block. Accepts fragments over a valid/ready stream, performs read-compare-conditional-write against a word-addressed depth buffer over separate read-request, read-response and write channels, and emits a per-fragment pass/fail result stream. Adds test-enable and write-mask control, a programmable clear value, out-of-range rejection, read bypass for NEVER/ALWAYS, and saturating pass/fail statistics counters.

## Interface
- Z_SIZE, 16, depth word width
- X_RES, 640, framebuffer width in pixels
- Y_RES, 480, framebuffer height in pixels
- X_W, $clog2(X_RES), x coordinate width
- Y_W, $clog2(Y_RES), y coordinate width
- ADDR_SIZE, 32, memory word-address width
- CNT_W, 32, statistics counter width

- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- frag_valid_i / frag_ready_o  in/out  1  fragment handshake
- frag_x_i, frag_y_i, frag_z_i  in  X_W, Y_W, Z_SIZE  fragment coordinates and depth
- depth_func_i  in  3  NEVER=0, LESS=1, LEQUAL=2, GREATER=3, GEQUAL=4, EQUAL=5, NOTEQUAL=6, ALWAYS=7
- depth_test_en_i, depth_write_en_i  in  1  test enable, write mask
- base_addr_i  in  ADDR_SIZE  buffer base word address
- clear_value_i  in  Z_SIZE  clear fill value
- clear_start_i  in  1  request full-buffer clear
- clear_busy_o, clear_done_o  out  1  clear in progress / one-cycle completion pulse
- rd_req_valid_o / rd_req_ready_i, rd_addr_o  out/in, out  1, ADDR_SIZE  read request
- rd_resp_valid_i / rd_resp_ready_o, rd_resp_data_i  in/out, in  1, Z_SIZE  read response
- wr_valid_o / wr_ready_i, wr_addr_o, wr_data_o  out/in, out  1, ADDR_SIZE, Z_SIZE  write
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_pass_o, res_x_o, res_y_o, res_z_o  out  1, X_W, Y_W, Z_SIZE  result and echoed fragment
- pass_cnt_o, fail_cnt_o  out  CNT_W  statistics
- stats_clr_i  in  1  synchronous counter clear

## Operation
- States: IDLE, RD_REQ, RD_RESP, WRITE, RESULT, CLEAR. Fragment, depth_func, enables and base_addr captured on accept; clear_value and base_addr captured on clear start.
- Address = base + y*X_RES + x, computed in ADDR_SIZE bits, wraps modulo 2^ADDR_SIZE.
- IDLE: clear_start_i -> CLEAR (priority over fragments). Else on frag accept:
  - x>=X_RES or y>=Y_RES -> RESULT, pass=0, no memory access.
  - test disabled -> RESULT, pass=1, no write.
  - NEVER -> RESULT, pass=0. ALWAYS -> WRITE if write_en, else RESULT; pass=1; no read.
  - otherwise -> RD_REQ.
- RD_REQ: rd_req_valid_o held with stable rd_addr_o until rd_req_ready_i -> RD_RESP.
- RD_RESP: rd_resp_ready_o=1; on handshake compare frag_z (unsigned, left operand) vs rd_resp_data_i; pass && write_en -> WRITE, else RESULT.
- WRITE: wr_valid_o held, wr_data_o=frag_z, until wr_ready_i -> RESULT.
- RESULT: res_valid_o held with stable payload until res_ready_i -> IDLE; counters update on this handshake.
- CLEAR: writes clear_value to base..base+X_RES*Y_RES-1 ascending, one word per wr handshake; last handshake -> IDLE, clear_done_o pulse.
- clear_start_i outside IDLE ignored. Counters saturate at all-ones; stats_clr_i wins over same-cycle increment.

## Timing
- Reset: state IDLE; all valid/ready outputs, clear_busy_o, clear_done_o, res_pass_o 0; addresses, data, echoed fields, counters 0.
- Reset mid-transaction: transaction abandoned, no result, no counter change.
- frag_ready_o = (state==IDLE) && !clear_start_i (combinational); all other outputs registered.
- Accept at cycle T: bypass -> res_valid_o at T+1; ALWAYS+write -> wr_valid_o T+1; read path with zero-wait handshakes: rd_req_valid_o T+1, rd_resp_ready_o T+2, res_valid_o T+3 (no write) or wr_valid_o T+3, res_valid_o T+4.
- Back-to-back: next frag_ready_o earliest cycle after result handshake.
- Clear: clear_busy_o high from cycle after start through last write handshake; clear_done_o high the following cycle only; zero-wait throughput one word/cycle.

## Test plan
- Clear with clear_value=0xFFFF, X_RES=4, Y_RES=4, base=0x100, wr_ready_i=1 -> 16 writes 0x100..0x10F, done pulse after 0x10F, busy 16 cycles.
- LESS, z=0x10, memory 0x20, write_en=1 -> write 0x10 to addr, res_pass=1, pass_cnt=1; repeat with memory 0x08 -> no write, pass=0, fail_cnt=1.
- All eight funcs with z==mem=0x40 -> pass only for LEQUAL, GEQUAL, EQUAL, ALWAYS; NEVER/ALWAYS issue no read.
- Random backpressure on rd_req_ready_i, wr_ready_i, res_ready_i -> valids and payloads stable until handshake, no duplicate transfers.
- x=X_RES, y=0 -> pass=0, no memory traffic, fail_cnt+1; test_en=0 -> pass=1, no traffic.
- rst_i asserted mid-WRITE -> all outputs reset immediately, counters 0, next fragment processed normally; stats_clr_i coincident with result -> counters 0.
